uart_tx_fifo: RTL and testbench

- Downstream stage of the APB UART slave: accepts bytes from the APB write path and serialises them onto the TX pin.
- Buffers bytes in a FIFO and reports FIFO-full, so the APB slave can stall PREADY instead of dropping writes.
- Serialises each byte as an 8N1 frame (1 start, 8 data LSB-first, 1 stop) at a fixed baud rate derived from the system clock.

---
 rtl/uart_defs.sv | 22 ++
 rtl/tx_byte_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the UART transmit path.
// State encodings, frame geometry and the baud divider helper.
package uart_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 8N1: start + 8 data + stop
    localparam int FRAME_BITS = 10;

    function automatic int clks_per_bit(
        input int clk_hz,
        input int baud
    );
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser.
// Flags and count are registered; head byte is read combinationally.
module tx_byte_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 8,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [AW:0]      count_nxt;

    // full is judged on the registered flag, so a push while full
    // is dropped even if a pop frees a slot in the same cycle
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // next occupancy from the qualified push/pop pair
    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // pointers wrap naturally, depth is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter behind the APB write path.
// FIFO absorbs bursts; full lets the slave stall instead of dropping.
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  tx_byte,
    input  logic        transmit,
    output logic        tx_fifo_full,
    output logic        tx_fifo_empty,
    output logic [AW:0] tx_fifo_count,
    output logic        overflow,
    output logic        busy,
    output logic        tx
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
    localparam logic [2:0]    DATA_LAST = 3'(FRAME_BITS - 3);

    tx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          push;
    logic          tick;
    logic          load;

    assign push = transmit & ~tx_fifo_full;
    assign tick = (baud_cnt == BAUD_LAST);

    // take the next byte from idle, or straight out of a stop bit
    // so consecutive frames carry no idle gap
    assign load = ~tx_fifo_empty &
                  ((state == IDLE) | ((state == STOP) & tick));

    assign busy = (state != IDLE) | ~tx_fifo_empty;

    tx_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8),
        .AW         (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .din   (tx_byte),
        .dout  (head),
        .full  (tx_fifo_full),
        .empty (tx_fifo_empty),
        .count (tx_fifo_count)
    );

    // frame sequencer: baud counter, shifter and registered tx line
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            overflow <= transmit & tx_fifo_full;
            if (load) begin
                shift    <= head;
                baud_cnt <= '0;
                state    <= START;
                tx       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                    end
                    START: begin
                        if (tick) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= DATA;
                            tx       <= shift[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            baud_cnt <= '0;
                            if (bit_idx == DATA_LAST) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shift   <= shift >> 1;
                                tx      <= shift[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            baud_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                        tx <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 16 clocks per bit.
// Line monitor decodes tx; frames also checked cycle by cycle.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_byte;
    logic       transmit;
    logic       tx_fifo_full;
    logic       tx_fifo_empty;
    logic [3:0] tx_fifo_count;
    logic       overflow;
    logic       busy;
    logic       tx;

    int total = 0;
    int bad   = 0;
    int busy_cnt;
    int ferr;
    logic gate_full;
    logic [7:0] pending[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (8),
        .AW         (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_byte       (tx_byte),
        .transmit      (transmit),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_count (tx_fifo_count),
        .overflow      (overflow),
        .busy          (busy),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        if (pending.size() > 0 && !(gate_full && tx_fifo_full)) begin
            transmit = 1'b1;
            tx_byte  = pending.pop_front();
        end else begin
            transmit = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (busy) busy_cnt++;
        drive();
    endtask

    task automatic do_reset();
        pending.delete();
        gate_full = 1'b0;
        reset = 1'b1;
        transmit = 1'b0;
        step();
        step();
        reset = 1'b0;
        rx_q.delete();
        ferr = 0;
    endtask

    task automatic check_frame(input logic [7:0] b, input string tag);
        int errs = 0;
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 160; i++) begin
            if (tx !== f[i/16]) errs++;
            step();
        end
        check(tag, errs, 0);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while ((busy || transmit || pending.size() > 0) && n < limit) begin
            step();
            n++;
        end
        check(tag, (n < limit) ? 1 : 0, 1);
        repeat (4) step();
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_n"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
        check({tag, "_ferr"}, ferr, 0);
    endtask

    // line monitor: mid-bit sampling of each 8N1 frame
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                logic [7:0] d;
                repeat (7) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (16) @(negedge clk);
                    d[k] = tx;
                end
                repeat (16) @(negedge clk);
                if (tx !== 1'b1) ferr++;
                rx_q.push_back(d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        tx_byte = 8'h00;
        busy_cnt = 0;
        do_reset();

        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", tx_fifo_empty, 1);
        check("rst_full", tx_fifo_full, 0);
        check("rst_count", tx_fifo_count, 0);
        check("rst_ovf", overflow, 0);

        // single byte
        busy_cnt = 0;
        pending = {8'hA5};
        drive();
        step();
        check("s_cnt1", tx_fifo_count, 1);
        check("s_empty", tx_fifo_empty, 0);
        check("s_busy", busy, 1);
        check("s_tx_idle", tx, 1);
        step();
        check("s_cnt0", tx_fifo_count, 0);
        check_frame(8'hA5, "s_frame");
        check("s_busy_fall", busy, 0);
        check("s_busy_len", busy_cnt, 161);
        check("s_tx_end", tx, 1);
        repeat (4) step();
        exp_q = {8'hA5};
        check_rx("s_rx");

        // back-to-back
        rx_q.delete();
        busy_cnt = 0;
        pending = {8'h00, 8'hFF, 8'h55};
        drive();
        step();
        step();
        check_frame(8'h00, "b_frame0");
        check_frame(8'hFF, "b_frame1");
        check_frame(8'h55, "b_frame2");
        check("b_busy_fall", busy, 0);
        check("b_busy_len", busy_cnt, 481);
        repeat (4) step();
        exp_q = {8'h00, 8'hFF, 8'h55};
        check_rx("b_rx");

        // full / overflow
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            pending.push_back(8'(i * 37 + 5));
            if (i < 9) exp_q.push_back(8'(i * 37 + 5));
        end
        drive();
        for (int c = 1; c <= 162; c++) begin
            step();
            if (c == 2) check("f_cnt_n2", tx_fifo_count, 1);
            if (c == 8) check("f_full_n8", tx_fifo_full, 0);
            if (c == 9) begin
                check("f_full_n9", tx_fifo_full, 1);
                check("f_cnt_n9", tx_fifo_count, 8);
                check("f_ovf_n9", overflow, 0);
            end
            if (c == 10) check("f_ovf_n10", overflow, 1);
            if (c == 11) check("f_ovf_n11", overflow, 0);
            if (c == 161) check("f_full_n161", tx_fifo_full, 1);
            if (c == 162) begin
                check("f_full_n162", tx_fifo_full, 0);
                check("f_cnt_n162", tx_fifo_count, 7);
            end
        end
        wait_idle(3000, "f_idle");
        check_rx("f_rx");

        // simultaneous push/pop and pointer wrap
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 20; i++)
            exp_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 9; i++)
            pending.push_back(exp_q[i]);
        drive();
        for (int c = 1; c <= 322; c++) begin
            step();
            if (c == 9) check("p_cnt_full", tx_fifo_count, 8);
            if (c == 321) begin
                check("p_cnt_pre", tx_fifo_count, 7);
                transmit = 1'b1;
                tx_byte = exp_q[9];
            end
            if (c == 322) begin
                check("p_cnt_same", tx_fifo_count, 7);
                check("p_ovf", overflow, 0);
            end
        end
        for (int i = 10; i < 20; i++)
            pending.push_back(exp_q[i]);
        gate_full = 1'b1;
        wait_idle(6000, "p_idle");
        gate_full = 1'b0;
        check_rx("p_rx");

        // reset in the middle of data bit 3
        do_reset();
        pending = {8'h11, 8'h22, 8'h33, 8'h44};
        drive();
        for (int c = 1; c <= 70; c++) step();
        check("r_cnt_pre", tx_fifo_count, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r_tx", tx, 1);
        check("r_cnt", tx_fifo_count, 0);
        check("r_busy", busy, 0);
        check("r_empty", tx_fifo_empty, 1);
        errs = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("r_quiet", errs, 0);
        rx_q.delete();
        ferr = 0;
        pending = {8'h3C};
        drive();
        step();
        step();
        check_frame(8'h3C, "r_frame");
        repeat (4) step();
        exp_q = {8'h3C};
        check_rx("r_rx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
